// File: rtl/controle_mem_dados.sv
// Data-memory responder for lw/sw: word-addressed RAM behind a fixed number of
// wait states, stalling the core until the access completes.
module controle_mem_dados #(
  parameter logic [31:0] BASE         = 32'h1001_0000,
  parameter int          PROFUNDIDADE = 256,
  parameter int          LATENCIA     = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iLeMem,
  input  logic        iEscreveMem,
  input  logic [31:0] iEndereco,
  input  logic [31:0] iDadoEscrita,
  output logic [31:0] oDadoLido,
  output logic        oStall,
  output logic        oErroAcesso,
  output logic [15:0] oNumAcessos
);

  localparam int IDX_W = $clog2(PROFUNDIDADE);
  localparam int CNT_W = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
  localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(LATENCIA - 1);
  localparam logic [32:0] LIMITE = {1'b0, BASE} + 33'(4 * PROFUNDIDADE);

  typedef enum logic [1:0] {OCIOSO, ESPERA, CONCLUI} estado_t;

  estado_t            estado;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        num_acessos;
  logic [31:0]        mem [PROFUNDIDADE];

  logic               req;
  logic               valido;
  logic [31:0]        desloc;
  logic [IDX_W-1:0]   idx_p0;

  logic [IDX_W-1:0]   idx_p1;
  logic [31:0]        dado_p1;
  logic               escrita_p1;
  logic               conclui_acesso;

  // Stage 0: decode and validate the request as presented by the datapath
  assign req    = iLeMem | iEscreveMem;
  assign desloc = iEndereco - BASE;
  assign idx_p0 = IDX_W'(desloc >> 2);
  assign valido = req && !(iLeMem && iEscreveMem) && (iEndereco[1:0] == 2'b00) &&
                  (iEndereco >= BASE) && ({1'b0, iEndereco} < LIMITE);

  assign conclui_acesso = (estado == ESPERA) && (cnt == '0);

  assign oStall      = ((estado == OCIOSO) && valido) || (estado == ESPERA);
  assign oNumAcessos = num_acessos;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      estado      <= OCIOSO;
      cnt         <= '0;
      oDadoLido   <= '0;
      oErroAcesso <= 1'b0;
      num_acessos <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (valido) begin
            estado <= ESPERA;
            cnt    <= CNT_INI;
          end else if (req) begin
            oErroAcesso <= 1'b1;
          end
        end
        ESPERA: begin
          if (cnt == '0) begin
            estado      <= CONCLUI;
            num_acessos <= num_acessos + 16'd1;
            if (!escrita_p1) oDadoLido <= mem[idx_p1];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CONCLUI: estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

  // Stage 1: latched request; the RAM write lands on the completion edge
  always_ff @(posedge iCLK) begin
    if ((estado == OCIOSO) && valido) begin
      idx_p1     <= idx_p0;
      dado_p1    <= iDadoEscrita;
      escrita_p1 <= iEscreveMem;
    end
    if (conclui_acesso && escrita_p1) mem[idx_p1] <= dado_p1;
  end

endmodule

// File: tb/tb_controle_mem_dados.sv
// Directed bench for controle_mem_dados: vector table of lw/sw/invalid requests
// plus hand sequences for reset, latched inputs and counter wrap.
module tb_controle_mem_dados;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iLeMem;
  logic        iEscreveMem;
  logic [31:0] iEndereco;
  logic [31:0] iDadoEscrita;
  logic [31:0] oDadoLido;
  logic        oStall;
  logic        oErroAcesso;
  logic [15:0] oNumAcessos;

  int total = 0;
  int bad   = 0;

  controle_mem_dados dut (
    .iCLK(iCLK), .iRST(iRST), .iLeMem(iLeMem), .iEscreveMem(iEscreveMem),
    .iEndereco(iEndereco), .iDadoEscrita(iDadoEscrita), .oDadoLido(oDadoLido),
    .oStall(oStall), .oErroAcesso(oErroAcesso), .oNumAcessos(oNumAcessos)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        le;
    logic        esc;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] dado;
    logic        erro;
    logic [15:0] num;
  } vec_t;

  vec_t tab [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 of the cycle after the final one.
  task automatic do_access(input logic le, input logic esc, input logic [31:0] a,
                           input logic [31:0] d, output int stalls);
    bit done;
    iLeMem = le; iEscreveMem = esc; iEndereco = a; iDadoEscrita = d;
    stalls = 0;
    done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      #3;
      if (oStall) stalls++;
      else done = 1;
      @(posedge iCLK); #1;
    end
    if (!done) chk("access_timeout", 32'(stalls), 32'd0);
    iLeMem = 1'b0; iEscreveMem = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    iRST = 1'b1; iLeMem = 1'b0; iEscreveMem = 1'b0; iEndereco = '0; iDadoEscrita = '0;

    tab[0]  = '{1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 3, 32'h0000_0000, 1'b0, 16'd1};
    tab[1]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, 16'd2};
    tab[2]  = '{1'b0, 1'b1, 32'h1001_000C, 32'h0BAD_F00D, 3, 32'hDEAD_BEEF, 1'b0, 16'd3};
    tab[3]  = '{1'b1, 1'b0, 32'h1001_000C, 32'h0000_0000, 3, 32'h0BAD_F00D, 1'b0, 16'd4};
    tab[4]  = '{1'b0, 1'b1, 32'h1001_03FC, 32'h1111_2222, 3, 32'h0BAD_F00D, 1'b0, 16'd5};
    tab[5]  = '{1'b1, 1'b0, 32'h1001_03FC, 32'h0000_0000, 3, 32'h1111_2222, 1'b0, 16'd6};
    tab[6]  = '{1'b1, 1'b0, 32'h1001_0006, 32'h0000_0000, 0, 32'h1111_2222, 1'b1, 16'd6};
    tab[7]  = '{1'b0, 1'b1, 32'h1001_0400, 32'hFFFF_FFFF, 0, 32'h1111_2222, 1'b1, 16'd6};
    tab[8]  = '{1'b1, 1'b1, 32'h1001_0008, 32'h5555_5555, 0, 32'h1111_2222, 1'b1, 16'd6};
    tab[9]  = '{1'b0, 1'b1, 32'h1000_FFFC, 32'h7777_7777, 0, 32'h1111_2222, 1'b1, 16'd6};
    tab[10] = '{1'b1, 1'b0, 32'h1001_0008, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b1, 16'd7};
    tab[11] = '{1'b1, 1'b0, 32'h1001_03FC, 32'h0000_0000, 3, 32'h1111_2222, 1'b1, 16'd8};
    tab[12] = '{1'b0, 1'b0, 32'h1001_0008, 32'h0000_0000, 0, 32'h1111_2222, 1'b1, 16'd8};

    #12 iRST = 1'b0;
    @(posedge iCLK); #1;
    chk("reset_stall", 32'(oStall), 32'd0);
    chk("reset_dado", oDadoLido, 32'h0);
    chk("reset_erro", 32'(oErroAcesso), 32'd0);
    chk("reset_num", 32'(oNumAcessos), 32'd0);

    for (int i = 0; i < 13; i++) begin
      do_access(tab[i].le, tab[i].esc, tab[i].addr, tab[i].wdata, st);
      chk($sformatf("vec%0d_stalls", i), 32'(st), 32'(tab[i].stalls));
      chk($sformatf("vec%0d_dado", i), oDadoLido, tab[i].dado);
      chk($sformatf("vec%0d_erro", i), 32'(oErroAcesso), 32'(tab[i].erro));
      chk($sformatf("vec%0d_num", i), 32'(oNumAcessos), 32'(tab[i].num));
    end

    // Inputs changed while waiting must not affect the latched write
    iLeMem = 1'b0; iEscreveMem = 1'b1; iEndereco = 32'h1001_0010; iDadoEscrita = 32'hAAAA_5555;
    #3 chk("latch_c0_stall", 32'(oStall), 32'd1);
    @(posedge iCLK); #1;
    iLeMem = 1'b1; iEscreveMem = 1'b0; iEndereco = 32'h1001_0014; iDadoEscrita = 32'h0;
    #3 chk("latch_c1_stall", 32'(oStall), 32'd1);
    @(posedge iCLK); #1;
    #3 chk("latch_c2_stall", 32'(oStall), 32'd1);
    @(posedge iCLK); #1;
    #3 chk("latch_conclui_stall", 32'(oStall), 32'd0);
    @(posedge iCLK); #1;
    iLeMem = 1'b0; iEscreveMem = 1'b0;
    chk("latch_num", 32'(oNumAcessos), 32'd9);
    do_access(1'b1, 1'b0, 32'h1001_0010, 32'h0, st);
    chk("latch_read_dado", oDadoLido, 32'hAAAA_5555);
    chk("latch_read_num", 32'(oNumAcessos), 32'd10);

    // Asynchronous reset in the middle of a cycle
    #2 iRST = 1'b1;
    #1;
    chk("async_rst_stall", 32'(oStall), 32'd0);
    chk("async_rst_dado", oDadoLido, 32'h0);
    chk("async_rst_erro", 32'(oErroAcesso), 32'd0);
    chk("async_rst_num", 32'(oNumAcessos), 32'd0);
    #3 iRST = 1'b0;
    @(posedge iCLK); #1;

    // Reset while a write waits must discard it
    do_access(1'b0, 1'b1, 32'h1001_0000, 32'h0000_0000, st);
    chk("pre_wr_stalls", 32'(st), 32'd3);
    iLeMem = 1'b0; iEscreveMem = 1'b1; iEndereco = 32'h1001_0000; iDadoEscrita = 32'h1234_5678;
    #3 chk("midwr_c0_stall", 32'(oStall), 32'd1);
    @(posedge iCLK); #1;
    #2 iRST = 1'b1; iEscreveMem = 1'b0;
    #1;
    chk("midwr_rst_stall", 32'(oStall), 32'd0);
    chk("midwr_rst_num", 32'(oNumAcessos), 32'd0);
    #3 iRST = 1'b0;
    @(posedge iCLK); #1;
    do_access(1'b1, 1'b0, 32'h1001_0000, 32'h0, st);
    chk("midwr_read_stalls", 32'(st), 32'd3);
    chk("midwr_read_dado", oDadoLido, 32'h0000_0000);
    chk("midwr_read_num", 32'(oNumAcessos), 32'd1);

    // Counter wrap: preload the count, then complete one more access
    #2 force dut.num_acessos = 16'hFFFF;
    #1 release dut.num_acessos;
    #1 chk("wrap_preload", 32'(oNumAcessos), 32'h0000_FFFF);
    @(posedge iCLK); #1;
    do_access(1'b1, 1'b0, 32'h1001_0008, 32'h0, st);
    chk("wrap_stalls", 32'(st), 32'd3);
    chk("wrap_num", 32'(oNumAcessos), 32'd0);
    chk("wrap_dado", oDadoLido, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
